instr_fetch_unit: RTL and testbench

//  Instruction-fetch stage directly upstream of the core datapath: takes the datapath's pc and returns instr.

---
 rtl/instr_fetch_unit_if.sv | 10 +
 rtl/instr_fetch_unit.sv | 123 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if: req/gnt/rvalid instruction memory read port
interface instr_fetch_unit_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  modport master(output mem_req, mem_addr, input mem_gnt, mem_rvalid, mem_rdata);
  modport slave(input mem_req, mem_addr, output mem_gnt, mem_rvalid, mem_rdata);
endinterface

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: 2-entry fetch buffer with next-word prefetch, stalls the datapath on a miss
module instr_fetch_unit #(
  parameter bit          PREFETCH_EN = 1'b1,
  parameter logic [31:0] NOP_INSTR   = 32'h0000_0013
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [31:0]               pc,
  input  logic                      flush,
  output logic [31:0]               instr,
  output logic                      instr_valid,
  output logic                      stall,
  instr_fetch_unit_if.master        mem
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
  state_t      state_q, state_d;
  logic [1:0]  valid_q, valid_d;
  logic [29:0] tag_q [2];
  logic [29:0] tag_d [2];
  logic [31:0] data_q [2];
  logic [31:0] data_d [2];
  logic        lru_q, lru_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic        req_slot_q, req_slot_d;
  logic        req_kill_q, req_kill_d;
  logic        mem_req_q, mem_req_d;
  logic [31:0] pc_al, nxt_addr;
  logic [1:0]  hit, nxt_hit;
  logic        hit_idx;
  assign pc_al       = pc & ~32'd3;
  assign nxt_addr    = pc_al + 32'd4;
  assign hit[0]      = valid_q[0] && ({tag_q[0], 2'b00} == pc_al);
  assign hit[1]      = valid_q[1] && ({tag_q[1], 2'b00} == pc_al);
  assign nxt_hit[0]  = valid_q[0] && ({tag_q[0], 2'b00} == nxt_addr);
  assign nxt_hit[1]  = valid_q[1] && ({tag_q[1], 2'b00} == nxt_addr);
  assign hit_idx     = ~hit[0];
  assign instr_valid = |hit;
  assign stall       = ~instr_valid;
  assign instr       = hit[0] ? data_q[0] : hit[1] ? data_q[1] : NOP_INSTR;
  assign mem.mem_req  = mem_req_q;
  assign mem.mem_addr = req_addr_q;
  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    tag_d      = tag_q;
    data_d     = data_q;
    lru_d      = lru_q;
    req_addr_d = req_addr_q;
    req_slot_d = req_slot_q;
    req_kill_d = req_kill_q;
    mem_req_d  = mem_req_q;
    case (state_q)
      IDLE: begin
        if (flush) begin
          valid_d = '0;
        end else if (!instr_valid) begin
          state_d    = REQ;
          mem_req_d  = 1'b1;
          req_addr_d = pc_al;
          req_slot_d = lru_q;
        end else begin
          lru_d = ~hit_idx;
          if (PREFETCH_EN && !(|nxt_hit)) begin
            state_d    = REQ;
            mem_req_d  = 1'b1;
            req_addr_d = nxt_addr;
            req_slot_d = ~hit_idx;
          end
        end
      end
      REQ: begin
        // the request stays on the bus after a flush; its data is dropped on return
        if (flush) begin
          valid_d    = '0;
          req_kill_d = 1'b1;
        end
        if (mem.mem_gnt) begin
          state_d   = WAIT;
          mem_req_d = 1'b0;
        end
      end
      WAIT: begin
        if (flush) begin
          valid_d    = '0;
          req_kill_d = 1'b1;
        end
        if (mem.mem_rvalid) begin
          if (!req_kill_q && !flush) begin
            valid_d[req_slot_q] = 1'b1;
            tag_d[req_slot_q]   = req_addr_q[31:2];
            data_d[req_slot_q]  = mem.mem_rdata;
          end
          req_kill_d = 1'b0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      valid_q    <= '0;
      tag_q      <= '{default: '0};
      data_q     <= '{default: '0};
      lru_q      <= 1'b0;
      req_addr_q <= '0;
      req_slot_q <= 1'b0;
      req_kill_q <= 1'b0;
      mem_req_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      tag_q      <= tag_d;
      data_q     <= data_d;
      lru_q      <= lru_d;
      req_addr_q <= req_addr_d;
      req_slot_q <= req_slot_d;
      req_kill_q <= req_kill_d;
      mem_req_q  <= mem_req_d;
    end
  end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed vector table plus hand sequences for the fetch buffer
module tb_instr_fetch_unit;
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc;
  logic        flush;
  logic [31:0] instr;
  logic        instr_valid;
  logic        stall;
  int          checks = 0;
  int          errors = 0;
  int          acc = 0;
  int          acc0;
  instr_fetch_unit_if bus();
  instr_fetch_unit dut (
    .clk(clk), .reset(reset), .pc(pc), .flush(flush),
    .instr(instr), .instr_valid(instr_valid), .stall(stall), .mem(bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (!reset && bus.mem_req && bus.mem_gnt) acc++;
  typedef struct {
    logic [31:0] pc;
    logic        gnt;
    logic        rv;
    logic [31:0] rdata;
    logic        ereq;
    logic [31:0] eaddr;
    logic        evalid;
    logic [31:0] einstr;
  } vec_t;
  vec_t tbl [10];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic drive(input logic [31:0] p, input logic f, input logic g, input logic rv, input logic [31:0] rd);
    pc = p;
    flush = f;
    bus.mem_gnt = g;
    bus.mem_rvalid = rv;
    bus.mem_rdata = rd;
    @(negedge clk);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk_reset_outs(input string tag);
    chk({tag, "_req"}, {31'd0, bus.mem_req}, 32'd0);
    chk({tag, "_addr"}, bus.mem_addr, 32'd0);
    chk({tag, "_valid"}, {31'd0, instr_valid}, 32'd0);
    chk({tag, "_instr"}, instr, NOP);
    chk({tag, "_stall"}, {31'd0, stall}, 32'd1);
  endtask
  initial begin
    tbl[0] = '{32'h0, 1'b0, 1'b0, 32'h0,          1'b0, 32'h0, 1'b0, NOP};
    tbl[1] = '{32'h0, 1'b1, 1'b0, 32'h0,          1'b1, 32'h0, 1'b0, NOP};
    tbl[2] = '{32'h0, 1'b0, 1'b1, 32'h0050_0093,  1'b0, 32'h0, 1'b0, NOP};
    tbl[3] = '{32'h0, 1'b0, 1'b0, 32'h0,          1'b0, 32'h0, 1'b1, 32'h0050_0093};
    tbl[4] = '{32'h0, 1'b1, 1'b0, 32'h0,          1'b1, 32'h4, 1'b1, 32'h0050_0093};
    tbl[5] = '{32'h0, 1'b0, 1'b1, 32'h0010_0113,  1'b0, 32'h0, 1'b1, 32'h0050_0093};
    tbl[6] = '{32'h4, 1'b0, 1'b0, 32'h0,          1'b0, 32'h0, 1'b1, 32'h0010_0113};
    tbl[7] = '{32'h4, 1'b1, 1'b0, 32'h0,          1'b1, 32'h8, 1'b1, 32'h0010_0113};
    tbl[8] = '{32'h4, 1'b0, 1'b1, 32'h0020_8193,  1'b0, 32'h0, 1'b1, 32'h0010_0113};
    tbl[9] = '{32'h8, 1'b0, 1'b0, 32'h0,          1'b0, 32'h0, 1'b1, 32'h0020_8193};
    reset = 1'b1;
    pc = '0;
    flush = 1'b0;
    bus.mem_gnt = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk_reset_outs("reset");
    tick();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].pc, 1'b0, tbl[i].gnt, tbl[i].rv, tbl[i].rdata);
      chk($sformatf("v%0d_req", i), {31'd0, bus.mem_req}, {31'd0, tbl[i].ereq});
      if (tbl[i].ereq) chk($sformatf("v%0d_addr", i), bus.mem_addr, tbl[i].eaddr);
      chk($sformatf("v%0d_valid", i), {31'd0, instr_valid}, {31'd0, tbl[i].evalid});
      chk($sformatf("v%0d_instr", i), instr, tbl[i].einstr);
      chk($sformatf("v%0d_stall", i), {31'd0, stall}, {31'd0, ~tbl[i].evalid});
      tick();
    end
    drive(32'h8, 1'b0, 1'b1, 1'b0, 32'h0);
    chk("pf_c_req", {31'd0, bus.mem_req}, 32'd1);
    chk("pf_c_addr", bus.mem_addr, 32'hC);
    tick();
    drive(32'h100, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("br_stall", {31'd0, stall}, 32'd1);
    chk("br_wait_noreq", {31'd0, bus.mem_req}, 32'd0);
    tick();
    drive(32'h100, 1'b0, 1'b0, 1'b1, 32'h00C0_0C13);
    chk("br_fill_stall", {31'd0, stall}, 32'd1);
    tick();
    drive(32'h100, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("br_idle_req", {31'd0, bus.mem_req}, 32'd0);
    chk("br_idle_stall", {31'd0, stall}, 32'd1);
    tick();
    drive(32'hC, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("dm100_req", {31'd0, bus.mem_req}, 32'd1);
    chk("dm100_addr", bus.mem_addr, 32'h100);
    chk("c_written_valid", {31'd0, instr_valid}, 32'd1);
    chk("c_written_instr", instr, 32'h00C0_0C13);
    tick();
    drive(32'h100, 1'b0, 1'b1, 1'b0, 32'h0);
    chk("dm100_gnt_addr", bus.mem_addr, 32'h100);
    chk("dm100_stall", {31'd0, stall}, 32'd1);
    tick();
    drive(32'h100, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("flush_stall", {31'd0, stall}, 32'd1);
    tick();
    drive(32'h100, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF);
    chk("kill_stall", {31'd0, stall}, 32'd1);
    tick();
    drive(32'h100, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("kill_discard_valid", {31'd0, instr_valid}, 32'd0);
    chk("kill_idle_req", {31'd0, bus.mem_req}, 32'd0);
    tick();
    acc0 = acc;
    for (int i = 0; i < 5; i++) begin
      drive(i == 0 ? 32'h8 : 32'h100, 1'b0, 1'b0, 1'b0, 32'h0);
      chk($sformatf("hold%0d_req", i), {31'd0, bus.mem_req}, 32'd1);
      chk($sformatf("hold%0d_addr", i), bus.mem_addr, 32'h100);
      if (i == 0) chk("flushed_8_valid", {31'd0, instr_valid}, 32'd0);
      tick();
    end
    drive(32'h100, 1'b0, 1'b1, 1'b0, 32'h0);
    chk("gnt_req", {31'd0, bus.mem_req}, 32'd1);
    tick();
    drive(32'h100, 1'b0, 1'b1, 1'b1, 32'h1234_5678);
    chk("post_gnt_noreq", {31'd0, bus.mem_req}, 32'd0);
    tick();
    drive(32'h100, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("refill_valid", {31'd0, instr_valid}, 32'd1);
    chk("refill_instr", instr, 32'h1234_5678);
    chk("accepted_once", acc - acc0, 32'd1);
    tick();
    drive(32'h100, 1'b0, 1'b1, 1'b0, 32'h0);
    chk("pf104_addr", bus.mem_addr, 32'h104);
    tick();
    drive(32'h100, 1'b0, 1'b0, 1'b1, 32'h0000_0104);
    tick();
    drive(32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("top_miss_stall", {31'd0, stall}, 32'd1);
    tick();
    drive(32'hFFFF_FFFC, 1'b0, 1'b1, 1'b0, 32'h0);
    chk("top_req", {31'd0, bus.mem_req}, 32'd1);
    chk("top_addr", bus.mem_addr, 32'hFFFF_FFFC);
    tick();
    drive(32'hFFFF_FFFC, 1'b0, 1'b0, 1'b1, 32'hA5A5_0001);
    tick();
    drive(32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("top_valid", {31'd0, instr_valid}, 32'd1);
    chk("top_instr", instr, 32'hA5A5_0001);
    tick();
    drive(32'hFFFF_FFFC, 1'b0, 1'b1, 1'b0, 32'h0);
    chk("wrap_req", {31'd0, bus.mem_req}, 32'd1);
    chk("wrap_addr", bus.mem_addr, 32'h0);
    tick();
    reset = 1'b1;
    drive(32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    reset = 1'b0;
    drive(32'hFFFF_FFFC, 1'b0, 1'b0, 1'b1, 32'h0BAD_0BAD);
    chk_reset_outs("midreset");
    tick();
    drive(32'hFFFF_FFFC, 1'b0, 1'b0, 1'b1, 32'h0BAD_0BAD);
    chk("after_reset_req", {31'd0, bus.mem_req}, 32'd1);
    chk("after_reset_addr", bus.mem_addr, 32'hFFFF_FFFC);
    chk("stale_rvalid_valid", {31'd0, instr_valid}, 32'd0);
    tick();
    drive(32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("rvalid_in_req_ignored", {31'd0, instr_valid}, 32'd0);
    chk("rvalid_in_req_instr", instr, NOP);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
